// File: rtl/wb_frame_assembler.sv
// wb_frame_assembler
// Collects three decoded words into a frame. Each frame starts with a K28.5 comma.
// Complete frames are queued in a small FIFO, which a Wishbone slave drains.
//
// Optional feature macro: WB_FRAME_ASSEMBLER_ERRCNT_EN
//   When defined, status[23:16] is a saturating count of alignment-error events.
//   When undefined, that counter does not exist and status[23:16] reads 0.
//
// state | meaning
// ------+-----------------------------------------------
// HUNT  | no partial frame; waiting for a comma
// GOT1  | comma captured as w0; waiting for w1
// GOT2  | w0 and w1 captured; the next data word completes the frame
module wb_frame_assembler #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] ADR_STATUS = 32'h0,
  parameter logic [31:0] ADR_DATA   = 32'h4
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [8:0]  word_i,
  input  logic        word_valid_i,
  input  logic        word_err_i,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic        ACK_O,
  output logic        ERR_O,
  output logic [31:0] DAT_O,
  output logic        irq_o
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [8:0] COMMA = 9'h1BC;

  typedef enum logic [1:0] {HUNT, GOT1, GOT2} state_t;

  state_t      state_q, state_d;
  logic [8:0]  w0_q, w0_d, w1_q, w1_d;
  logic        push;
  logic        align_evt;
  logic [26:0] push_frame;

  logic [26:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  logic          full, empty;
  logic          pop, push_ok, overflow_set;

  logic        overflow_q, align_err_q;
  logic [7:0]  err_cnt;
  logic [31:0] status;

  logic bus_act, sel_status, sel_data;
  logic status_rd, status_wr, data_rd_ok;
  logic clr_ovf, clr_align, clr_cnt;

  // Assembler state and captured words.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= HUNT;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  // Next-state decode. A decode error always aborts the frame in progress.
  always_comb begin
    state_d    = state_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    push       = 1'b0;
    align_evt  = 1'b0;
    push_frame = {w0_q, w1_q, word_i};
    if (word_valid_i) begin
      if (word_err_i) begin
        state_d   = HUNT;
        align_evt = 1'b1;
      end else begin
        case (state_q)
          HUNT: begin
            if (word_i == COMMA) begin
              w0_d    = word_i;
              state_d = GOT1;
            end
          end
          GOT1: begin
            if (word_i == COMMA) begin
              w0_d      = word_i;
              align_evt = 1'b1;
            end else begin
              w1_d    = word_i;
              state_d = GOT2;
            end
          end
          GOT2: begin
            if (word_i == COMMA) begin
              w0_d      = word_i;
              state_d   = GOT1;
              align_evt = 1'b1;
            end else begin
              push    = 1'b1;
              state_d = HUNT;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  // Pop only ever happens when the FIFO is non-empty. When full, a push still
  // succeeds if a pop happens in the same cycle and frees the slot.
  assign push_ok      = push & (~full | pop);
  assign overflow_set = push & full & ~pop;

  // FIFO pointers and occupancy. The pointer widths make them wrap naturally.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop)     rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Frame storage. No reset is needed because the pointers gate visibility.
  always_ff @(posedge CLK_I) begin
    if (push_ok && !RST_I) mem[wptr_q] <= push_frame;
  end

  assign bus_act    = CYC_I & STB_I;
  assign sel_status = (ADR_I == ADR_STATUS);
  assign sel_data   = (ADR_I == ADR_DATA);
  assign status_rd  = bus_act & sel_status & ~WE_I;
  assign status_wr  = bus_act & sel_status & WE_I;
  assign data_rd_ok = bus_act & sel_data & ~WE_I & ~empty;
  assign pop        = data_rd_ok;

  assign clr_ovf   = status_wr & DAT_I[10];
  assign clr_align = status_wr & DAT_I[11];
  assign clr_cnt   = status_wr & DAT_I[16];

  // Sticky error flags. A set event in the same cycle as its clear wins.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      overflow_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      if (overflow_set)   overflow_q <= 1'b1;
      else if (clr_ovf)   overflow_q <= 1'b0;
      if (align_evt)      align_err_q <= 1'b1;
      else if (clr_align) align_err_q <= 1'b0;
    end
  end

`ifdef WB_FRAME_ASSEMBLER_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [28:0] dat_unused;
  assign dat_unused = {DAT_I[31:17], DAT_I[15:12], DAT_I[9:0]};

  // Saturating alignment-error counter. An event during a clear counts as 1.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      err_cnt_q <= 8'h00;
    end else if (align_evt) begin
      if (clr_cnt)                 err_cnt_q <= 8'h01;
      else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
    end else if (clr_cnt) begin
      err_cnt_q <= 8'h00;
    end
  end

  assign err_cnt = err_cnt_q;
`else
  logic [29:0] dat_unused;
  assign dat_unused = {DAT_I[31:16], DAT_I[15:12], DAT_I[9:0]};
  assign err_cnt    = 8'h00;
`endif

  assign status = {8'h00, err_cnt, 4'h0, align_err_q, overflow_q, full, empty,
                   {(8-CW){1'b0}}, count_q};

  // Wishbone slave outputs are purely combinational; ERR_O covers every access
  // that does not get an ACK_O.
  always_comb begin
    ACK_O = bus_act & (sel_status | data_rd_ok);
    ERR_O = bus_act & ~(sel_status | data_rd_ok);
    DAT_O = 32'h0;
    if (status_rd)       DAT_O = status;
    else if (data_rd_ok) DAT_O = {5'b0, mem[rptr_q]};
  end

  assign irq_o = ~empty;

endmodule

// File: tb/tb_wb_frame_assembler.sv
// Self-checking bench for wb_frame_assembler (default FIFO_DEPTH = 4).
module tb_wb_frame_assembler;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic [8:0]  word_i = '0;
  logic        word_valid_i = 1'b0;
  logic        word_err_i = 1'b0;
  logic        CYC_I = 1'b0, STB_I = 1'b0, WE_I = 1'b0;
  logic [31:0] ADR_I = '0, DAT_I = '0;
  logic        ACK_O, ERR_O, irq_o;
  logic [31:0] DAT_O;

  int tests = 0;
  int fails = 0;

  wb_frame_assembler dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .word_i(word_i), .word_valid_i(word_valid_i),
    .word_err_i(word_err_i), .CYC_I(CYC_I), .STB_I(STB_I), .WE_I(WE_I),
    .ADR_I(ADR_I), .DAT_I(DAT_I), .ACK_O(ACK_O), .ERR_O(ERR_O),
    .DAT_O(DAT_O), .irq_o(irq_o)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [26:0] words;
    logic [2:0]  errs;
    logic        cnt;
    logic [26:0] frame;
    logic        al;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] st(input int cnt, input bit ovf, input bit al, input int ec);
    logic [31:0] s;
    s = 32'h0;
    s[7:0] = cnt[7:0];
    s[8] = (cnt == 0);
    s[9] = (cnt == 4);
    s[10] = ovf;
    s[11] = al;
`ifdef WB_FRAME_ASSEMBLER_ERRCNT_EN
    s[23:16] = (ec > 255) ? 8'hFF : ec[7:0];
`endif
    return s;
  endfunction

  function automatic logic [31:0] fr(input int k);
    logic [8:0] a, b;
    a = k[8:0];
    b = 9'(k + 16);
    return {5'b0, 9'h1BC, a, b};
  endfunction

  task automatic tick();
    @(posedge CLK_I);
    #1;
  endtask

  task automatic do_reset();
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] w, input logic e);
    word_i = w; word_valid_i = 1'b1; word_err_i = e;
    tick();
    word_valid_i = 1'b0; word_err_i = 1'b0;
  endtask

  task automatic send_frame(input int k);
    logic [31:0] f;
    f = fr(k);
    send_word(9'h1BC, 1'b0);
    send_word(f[17:9], 1'b0);
    send_word(f[8:0], 1'b0);
  endtask

  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rd, output logic ack, output logic err);
    CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = dat;
    #4;
    rd = DAT_O; ack = ACK_O; err = ERR_O;
    tick();
    CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = '0; DAT_I = '0;
  endtask

  task automatic chk_status(input string name, input logic [31:0] exp);
    logic [31:0] rd; logic a, e;
    bus(1'b0, 32'h0, 32'h0, rd, a, e);
    chk(name, rd, exp);
  endtask

  task automatic chk_data(input string name, input logic [31:0] exp);
    logic [31:0] rd; logic a, e;
    bus(1'b0, 32'h4, 32'h0, rd, a, e);
    chk({name, "_ack"}, {30'h0, a, e}, 32'h2);
    chk(name, rd, exp);
  endtask

  vec_t vecs[8];

  logic [26:0] q[$];
  logic [8:0]  part[$];
  bit          m_ovf, m_al;
  int          m_ec;

  initial begin
    logic [31:0] rd;
    logic a, e;

    vecs[0] = '{words: {9'h1BC, 9'h012, 9'h034}, errs: 3'b000, cnt: 1'b1, frame: {9'h1BC, 9'h012, 9'h034}, al: 1'b0};
    vecs[1] = '{words: {9'h1BC, 9'h1BC, 9'h034}, errs: 3'b000, cnt: 1'b0, frame: 27'h0, al: 1'b1};
    vecs[2] = '{words: {9'h012, 9'h1BC, 9'h034}, errs: 3'b000, cnt: 1'b0, frame: 27'h0, al: 1'b0};
    vecs[3] = '{words: {9'h1BC, 9'h0FF, 9'h1BC}, errs: 3'b000, cnt: 1'b0, frame: 27'h0, al: 1'b1};
    vecs[4] = '{words: {9'h1BC, 9'h012, 9'h034}, errs: 3'b010, cnt: 1'b0, frame: 27'h0, al: 1'b1};
    vecs[5] = '{words: {9'h1BC, 9'h17C, 9'h1FC}, errs: 3'b000, cnt: 1'b1, frame: {9'h1BC, 9'h17C, 9'h1FC}, al: 1'b0};
    vecs[6] = '{words: {9'h1BC, 9'h012, 9'h034}, errs: 3'b100, cnt: 1'b0, frame: 27'h0, al: 1'b1};
    vecs[7] = '{words: {9'h0BC, 9'h012, 9'h034}, errs: 3'b000, cnt: 1'b0, frame: 27'h0, al: 1'b0};

    // Reset state with the bus idle.
    do_reset();
    #4;
    chk("rst_outputs", {28'h0, irq_o, ACK_O, ERR_O, 1'b0}, 32'h0);
    chk("rst_dat", DAT_O, 32'h0);
    tick();
    chk_status("rst_status", st(0, 0, 0, 0));

    // Table-driven single-frame vectors, each from a fresh reset.
    for (int i = 0; i < 8; i++) begin
      do_reset();
      for (int j = 0; j < 3; j++)
        send_word(vecs[i].words[26-9*j -: 9], vecs[i].errs[2-j]);
      chk_status($sformatf("vec%0d_status", i), st(vecs[i].cnt, 0, vecs[i].al, vecs[i].al));
      if (vecs[i].cnt) chk_data($sformatf("vec%0d_data", i), {5'b0, vecs[i].frame});
    end

    // Basic frame: readable the cycle after the last word.
    do_reset();
    send_word(9'h1BC, 0); send_word(9'h012, 0); send_word(9'h034, 0);
    #4; chk("basic_irq", {31'h0, irq_o}, 32'h1); tick();
    chk_data("basic_data", 32'h06F02434);
    chk_status("basic_status", st(0, 0, 0, 0));
    #4; chk("basic_irq_clr", {31'h0, irq_o}, 32'h0); tick();

    // Realignment on a second comma.
    do_reset();
    send_word(9'h012, 0); send_word(9'h1BC, 0); send_word(9'h0AA, 0);
    send_word(9'h1BC, 0); send_word(9'h011, 0); send_word(9'h022, 0);
    chk_status("realign_status", st(1, 0, 1, 1));
    chk_data("realign_data", 32'h06F02222);

    // Overflow: five frames into a depth-4 buffer.
    do_reset();
    for (int k = 1; k <= 5; k++) send_frame(k);
    chk_status("ovf_status", st(4, 1, 0, 0));
    for (int k = 1; k <= 4; k++) chk_data($sformatf("ovf_data%0d", k), fr(k));
    chk_status("ovf_drained", st(0, 1, 0, 0));

    // Empty read, then W1C clear.
    send_word(9'h000, 1'b1);
    bus(1'b0, 32'h4, 32'h0, rd, a, e);
    chk("empty_rd_ackerr", {30'h0, a, e}, 32'h1);
    chk("empty_rd_dat", rd, 32'h0);
    chk_status("pre_clear", st(0, 1, 1, 1));
    bus(1'b1, 32'h0, 32'h00010C00, rd, a, e);
    chk("w1c_ack", {30'h0, a, e}, 32'h2);
    chk_status("post_clear", st(0, 0, 0, 0));

    // A set event coincident with its clear wins.
    word_i = 9'h000; word_valid_i = 1'b1; word_err_i = 1'b1;
    bus(1'b1, 32'h0, 32'h00000800, rd, a, e);
    word_valid_i = 1'b0; word_err_i = 1'b0;
    chk_status("set_wins", st(0, 0, 1, 1));

    // Illegal accesses.
    bus(1'b1, 32'h4, 32'h1234, rd, a, e);
    chk("wr_data_err", {30'h0, a, e}, 32'h1);
    bus(1'b0, 32'h8, 32'h0, rd, a, e);
    chk("bad_adr_err", {30'h0, a, e}, 32'h1);
    chk("bad_adr_dat", rd, 32'h0);

    // Full FIFO with simultaneous push and pop.
    do_reset();
    for (int k = 1; k <= 4; k++) send_frame(k);
    send_word(9'h1BC, 0); send_word(9'h055, 0);
    word_i = 9'h066; word_valid_i = 1'b1;
    bus(1'b0, 32'h4, 32'h0, rd, a, e);
    word_valid_i = 1'b0;
    chk("pp_ack", {30'h0, a, e}, 32'h2);
    chk("pp_data", rd, fr(1));
    chk_status("pp_status", st(4, 0, 0, 0));
    for (int k = 2; k <= 4; k++) chk_data($sformatf("pp_data%0d", k), fr(k));
    chk_data("pp_data5", {5'b0, 9'h1BC, 9'h055, 9'h066});

    // Reset mid-frame; a word during reset is ignored.
    do_reset();
    send_word(9'h1BC, 0); send_word(9'h012, 0);
    RST_I = 1'b1; word_i = 9'h1BC; word_valid_i = 1'b1;
    tick();
    RST_I = 1'b0; word_valid_i = 1'b0;
    send_word(9'h034, 0); send_word(9'h1BC, 0); send_word(9'h001, 0); send_word(9'h002, 0);
    chk_status("midrst_status", st(1, 0, 0, 0));
    chk_data("midrst_data", 32'h06F00202);

    // Randomized traffic against a frame-level model.
    do_reset();
    q.delete(); part.delete(); m_ovf = 0; m_al = 0; m_ec = 0;
    for (int it = 0; it < 600; it++) begin
      logic rd_en, v, er;
      logic [8:0] w;
      rd_en = ($urandom_range(0, 3) == 0);
      v = ($urandom_range(0, 2) != 0);
      w = ($urandom_range(0, 3) == 0) ? 9'h1BC : 9'($urandom_range(0, 511));
      er = ($urandom_range(0, 15) == 0);
      word_i = w; word_valid_i = v; word_err_i = er;
      CYC_I = rd_en; STB_I = rd_en; WE_I = 1'b0; ADR_I = 32'h4;
      #4;
      chk("rnd_irq", {31'h0, irq_o}, {31'h0, q.size() > 0});
      if (rd_en && q.size() > 0) begin
        chk("rnd_ack", {30'h0, ACK_O, ERR_O}, 32'h2);
        chk("rnd_data", DAT_O, {5'b0, q[0]});
        void'(q.pop_front());
      end else begin
        chk("rnd_ackerr", {30'h0, ACK_O, ERR_O}, {30'h0, 1'b0, rd_en});
        chk("rnd_dat0", DAT_O, 32'h0);
      end
      if (v) begin
        if (er) begin
          part.delete(); m_al = 1; m_ec++;
        end else if (w == 9'h1BC) begin
          if (part.size() > 0) begin m_al = 1; m_ec++; end
          part.delete(); part.push_back(w);
        end else if (part.size() > 0) begin
          part.push_back(w);
          if (part.size() == 3) begin
            if (q.size() < 4) q.push_back({part[0], part[1], part[2]});
            else m_ovf = 1;
            part.delete();
          end
        end
      end
      tick();
      word_valid_i = 1'b0; word_err_i = 1'b0; CYC_I = 1'b0; STB_I = 1'b0;
    end
    chk_status("rnd_final_status", st(q.size(), m_ovf, m_al, m_ec));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
